axi_lite_reg_slave: RTL and testbench

//   Parametrised AXI4-Lite slave: all five channels (AW, W, B, AR, R) with full handshakes,

---
 rtl/axi_lite_reg_slave_if.sv | 61 ++++++
 rtl/axi_lite_reg_slave.sv | 192 +++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave_if
//   AXI4-Lite bus bundle (AW, W, B, AR, R channels) between an interconnect
//   master and the register slave.
//   Parameters: ADDR_W (address width), DATA_W (data width, 32 or 64).
//   Modports:   master drives requests and the B/R ready signals;
//               slave  drives the ready signals and the B/R responses.
// ----------------------------------------------------------------------------
interface axi_lite_reg_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Write address channel
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_W-1:0]     AWADDR;
    logic [2:0]            AWPROT;
    // Write data channel
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    // Write response channel
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    // Read address channel
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic [2:0]            ARPROT;
    // Read data channel
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT,
        output WVALID, WDATA, WSTRB,
        output BREADY,
        output ARVALID, ARADDR, ARPROT,
        output RREADY,
        input  AWREADY, WREADY,
        input  BVALID, BRESP,
        input  ARREADY,
        input  RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT,
        input  WVALID, WDATA, WSTRB,
        input  BREADY,
        input  ARVALID, ARADDR, ARPROT,
        input  RREADY,
        output AWREADY, WREADY,
        output BVALID, BRESP,
        output ARREADY,
        output RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// axi_lite_reg_slave
//   Generic AXI4-Lite CSR block: NREGS memory-mapped registers behind a full
//   five-channel AXI4-Lite slave. AW and W are captured independently into
//   holding registers and committed together with byte strobes; reads are
//   served one beat per two cycles. Register contents are exported to fabric.
//
//   Parameters: ADDR_W, DATA_W (32 or 64), NREGS (>=1), RESET_VAL.
//   Ports:
//     ACLK      clock, rising edge
//     ARESET    synchronous reset, active-high
//     bus       axi_lite_reg_slave_if.slave (AW, W, B, AR, R channels)
//     reg_q     register contents, reg i at [i*DATA_W +: DATA_W]
//     wr_pulse  one-cycle strobe per register, raised with the committed value
//
//   Build option: define AXIL_PROT_CHECK_EN to reject unprivileged
//   (PROT[0]=0) accesses to register 0 with SLVERR. Undefined, PROT is ignored.
// ----------------------------------------------------------------------------
module axi_lite_reg_slave #(
    parameter int unsigned      ADDR_W    = 32,
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      NREGS     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_lite_reg_slave_if.slave     bus,
    output logic [NREGS*DATA_W-1:0] reg_q,
    output logic [NREGS-1:0]        wr_pulse
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam int unsigned SEL_W  = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Elaboration guard on supported configurations
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("axi_lite_reg_slave: DATA_W must be 32 or 64");
    end
    if (NREGS < 1) begin : g_bad_nregs
        $error("axi_lite_reg_slave: NREGS must be at least 1");
    end

    // Register bank
    logic [DATA_W-1:0] regs [NREGS];

    // Write holding registers
    logic              aw_full;
    logic [IDX_W-1:0]  aw_idx;
    logic              w_full;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
`ifdef AXIL_PROT_CHECK_EN
    logic              aw_priv;
`endif

    // Response registers
    logic              b_valid;
    logic [1:0]        b_resp;
    logic              r_valid;
    logic [1:0]        r_resp;
    logic [DATA_W-1:0] r_data;

    // Decode results
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_ok;
    logic              rd_ok;
    logic [SEL_W-1:0]  wr_sel;
    logic [SEL_W-1:0]  rd_sel;
    logic [DATA_W-1:0] rd_mux;
    logic              commit;

    // Address offset bits and unchecked PROT bits carry no meaning here
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.AWPROT, bus.ARPROT,
                         bus.AWADDR[OFF_W-1:0], bus.ARADDR[OFF_W-1:0]};

    // Handshake readiness; all ready lines held low while in reset
    assign bus.AWREADY = !aw_full && !ARESET;
    assign bus.WREADY  = !w_full  && !ARESET;
    assign bus.ARREADY = !r_valid && !ARESET;
    assign bus.BVALID  = b_valid;
    assign bus.BRESP   = b_resp;
    assign bus.RVALID  = r_valid;
    assign bus.RRESP   = r_resp;
    assign bus.RDATA   = r_data;

    // Write commits only once both halves are held and no response is pending
    assign commit = aw_full && w_full && !b_valid;

    // Address decode and access check for both paths
    always_comb begin
        rd_idx = bus.ARADDR[ADDR_W-1:OFF_W];
        wr_ok  = (aw_idx < IDX_W'(NREGS));
        rd_ok  = (rd_idx < IDX_W'(NREGS));
`ifdef AXIL_PROT_CHECK_EN
        if (aw_idx == '0 && !aw_priv) begin
            wr_ok = 1'b0;
        end
        if (rd_idx == '0 && !bus.ARPROT[0]) begin
            rd_ok = 1'b0;
        end
`endif
        wr_sel = SEL_W'(aw_idx);
        rd_sel = SEL_W'(rd_idx);
        rd_mux = rd_ok ? regs[rd_sel] : '0;
    end

    // Flatten register bank for export
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    // Write path, read path and register bank
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
`ifdef AXIL_PROT_CHECK_EN
            aw_priv  <= 1'b0;
`endif
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
            r_valid  <= 1'b0;
            r_resp   <= RESP_OKAY;
            r_data   <= '0;
            wr_pulse <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            wr_pulse <= '0;

            // AW capture
            if (bus.AWVALID && !aw_full) begin
                aw_full <= 1'b1;
                aw_idx  <= bus.AWADDR[ADDR_W-1:OFF_W];
`ifdef AXIL_PROT_CHECK_EN
                aw_priv <= bus.AWPROT[0];
`endif
            end

            // W capture
            if (bus.WVALID && !w_full) begin
                w_full <= 1'b1;
                w_data <= bus.WDATA;
                w_strb <= bus.WSTRB;
            end

            // B handshake; cannot coincide with commit since commit needs !b_valid
            if (b_valid && bus.BREADY) begin
                b_valid <= 1'b0;
            end

            // Commit: strobed byte update, response and pulse on the same edge
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (w_strb[b]) begin
                            regs[wr_sel][b*8 +: 8] <= w_data[b*8 +: 8];
                        end
                    end
                    wr_pulse[wr_sel] <= 1'b1;
                end
            end

            // Read: sample the bank before any same-edge commit lands
            if (bus.ARVALID && !r_valid) begin
                r_valid <= 1'b1;
                r_data  <= rd_mux;
                r_resp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_valid && bus.RREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_reg_slave
//   Self-checking bench for axi_lite_reg_slave (DATA_W=32, NREGS=16).
//   Table of read/write vectors with B/R expectations queued on issue and
//   compared on the response handshake, plus hand-written multi-cycle cases.
// ----------------------------------------------------------------------------
module tb_axi_lite_reg_slave;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 16;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLV  = 2'b10;
`ifdef AXIL_PROT_CHECK_EN
    localparam logic [1:0]  PROT_RESP = 2'b10;
    localparam logic [31:0] PROT_RD   = 32'h0000_0000;
`else
    localparam logic [1:0]  PROT_RESP = 2'b00;
    localparam logic [31:0] PROT_RD   = 32'h2222_2222;
`endif

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    logic [NREGS*DATA_W-1:0] reg_q;
    logic [NREGS-1:0]        wr_pulse;

    axi_lite_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi_lite_reg_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NREGS    (NREGS),
        .RESET_VAL('0)
    ) dut (
        .ACLK    (aclk),
        .ARESET  (areset),
        .bus     (bus.slave),
        .reg_q   (reg_q),
        .wr_pulse(wr_pulse)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [1:0]  resp;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  bq [$];
    rexp_t       rq [$];
    logic [31:0] mdl [NREGS];
    vec_t        tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] rq_reg(input int i);
        return reg_q[i*32 +: 32];
    endfunction

    // Bench model of the register bank: strobed byte merge
    task automatic mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr[31:2]);
        if (idx < int'(NREGS)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic wait_b();
        bit got;
        logic [1:0] exp;
        got = 1'b0;
        bus.BREADY = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            if (bus.BVALID) begin
                got = 1'b1;
                exp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
                check("bresp", 64'(bus.BRESP), 64'(exp));
            end
            cyc();
        end
        bus.BREADY = 1'b0;
        if (!got) check("b_timeout", 64'(0), 64'(1));
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             input logic [1:0] exp_resp);
        bit aw_done, w_done, a_hs, w_hs;
        bq.push_back(exp_resp);
        bus.AWADDR = addr; bus.AWPROT = prot; bus.AWVALID = 1'b1;
        bus.WDATA  = data; bus.WSTRB  = strb; bus.WVALID  = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int i = 0; i < 50 && !(aw_done && w_done); i++) begin
            @(negedge aclk);
            a_hs = bus.AWVALID && bus.AWREADY;
            w_hs = bus.WVALID && bus.WREADY;
            cyc();
            if (a_hs) begin aw_done = 1'b1; bus.AWVALID = 1'b0; end
            if (w_hs) begin w_done  = 1'b1; bus.WVALID  = 1'b0; end
        end
        if (!(aw_done && w_done)) check("aw_w_timeout", 64'(0), 64'(1));
        wait_b();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                            input logic [1:0] exp_resp, input logic [31:0] exp_data);
        bit done, got;
        rexp_t e;
        rq.push_back('{resp: exp_resp, data: exp_data});
        bus.ARADDR = addr; bus.ARPROT = prot; bus.ARVALID = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            done = bus.ARREADY;
            cyc();
        end
        bus.ARVALID = 1'b0;
        if (!done) check("ar_timeout", 64'(0), 64'(1));
        got = 1'b0;
        bus.RREADY = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge aclk);
            if (bus.RVALID) begin
                got = 1'b1;
                e = (rq.size() > 0) ? rq.pop_front() : '{resp: 2'bxx, data: 'x};
                check("rresp", 64'(bus.RRESP), 64'(e.resp));
                check("rdata", 64'(bus.RDATA), 64'(e.data));
            end
            cyc();
        end
        bus.RREADY = 1'b0;
        if (!got) check("r_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h0C, 32'h0000_0001, 4'hF, 3'b001, OKAY};
        tbl[1]  = '{1'b0, 32'h0C, 32'h0000_0001, 4'h0, 3'b001, OKAY};
        tbl[2]  = '{1'b1, 32'h11, 32'h1234_5678, 4'hF, 3'b001, OKAY};
        tbl[3]  = '{1'b0, 32'h13, 32'h1234_5678, 4'h0, 3'b001, OKAY};
        tbl[4]  = '{1'b1, 32'h14, 32'hAABB_CCDD, 4'h5, 3'b001, OKAY};
        tbl[5]  = '{1'b0, 32'h14, 32'h00BB_00DD, 4'h0, 3'b001, OKAY};
        tbl[6]  = '{1'b1, 32'h18, 32'hFFFF_FFFF, 4'h0, 3'b001, OKAY};
        tbl[7]  = '{1'b0, 32'h18, 32'h0000_0000, 4'h0, 3'b001, OKAY};
        tbl[8]  = '{1'b0, 32'h40, 32'h0000_0000, 4'h0, 3'b001, SLV};
        tbl[9]  = '{1'b1, 32'h44, 32'h1111_1111, 4'hF, 3'b001, SLV};
        tbl[10] = '{1'b0, 32'h3C, 32'h0000_0000, 4'h0, 3'b001, OKAY};
        tbl[11] = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 3'b001, OKAY};
        tbl[12] = '{1'b0, 32'h3C, 32'hCAFE_F00D, 4'h0, 3'b001, OKAY};
        tbl[13] = '{1'b1, 32'h00, 32'h1111_1111, 4'hF, 3'b000, PROT_RESP};
        tbl[14] = '{1'b1, 32'h00, 32'h2222_2222, 4'hF, 3'b001, OKAY};
        tbl[15] = '{1'b0, 32'h00, 32'h2222_2222, 4'h0, 3'b001, OKAY};
        tbl[16] = '{1'b0, 32'h00, PROT_RD,       4'h0, 3'b000, PROT_RESP};
        tbl[17] = '{1'b0, 32'h08, 32'hDEAD_BEAA, 4'h0, 3'b001, OKAY};

        for (int i = 0; i < int'(NREGS); i++) mdl[i] = '0;
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWPROT = 3'b001;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB  = '0;
        bus.BREADY  = 1'b0;
        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = 3'b001;
        bus.RREADY  = 1'b0;

        // Reset state
        areset = 1'b1;
        repeat (3) cyc();
        @(negedge aclk);
        check("rst_ready", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(0));
        check("rst_valid", 64'({bus.BVALID, bus.RVALID}), 64'(0));
        check("rst_resp_rdata", 64'({bus.BRESP, bus.RRESP, bus.RDATA}), 64'(0));
        check("rst_wr_pulse", 64'(wr_pulse), 64'(0));
        check("rst_reg_q_zero", 64'(reg_q == '0), 64'(1));
        cyc();
        areset = 1'b0;
        @(negedge aclk);
        check("ready_after_rst", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'(3'b111));
        cyc();

        // AW+W same cycle: BVALID two cycles later with wr_pulse[2]
        bus.AWADDR = 32'h08; bus.AWPROT = 3'b001; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.BREADY = 1'b1;
        @(negedge aclk);
        check("aw_w_ready", 64'({bus.AWREADY, bus.WREADY}), 64'(2'b11));
        cyc();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        @(negedge aclk);
        check("bvalid_n1", 64'(bus.BVALID), 64'(0));
        cyc();
        @(negedge aclk);
        check("bvalid_n2", 64'(bus.BVALID), 64'(1));
        check("bresp_n2", 64'(bus.BRESP), 64'(OKAY));
        check("wr_pulse_n2", 64'(wr_pulse), 64'(16'h0004));
        check("reg2_beef", 64'(rq_reg(2)), 64'(32'hDEAD_BEEF));
        cyc();
        bus.BREADY = 1'b0;
        @(negedge aclk);
        check("bvalid_cleared", 64'(bus.BVALID), 64'(0));
        check("wr_pulse_1cyc", 64'(wr_pulse), 64'(0));
        cyc();
        mdl[2] = 32'hDEAD_BEEF;

        // W three cycles ahead of AW: WREADY held low until commit
        bus.WDATA = 32'h0000_00AA; bus.WSTRB = 4'h1; bus.WVALID = 1'b1;
        @(negedge aclk);
        cyc();
        bus.WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("wready_held", 64'(bus.WREADY), 64'(0));
            cyc();
        end
        bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
        bq.push_back(OKAY);
        @(negedge aclk);
        cyc();
        bus.AWVALID = 1'b0;
        wait_b();
        mdl_write(32'h08, 32'h0000_00AA, 4'h1);
        check("reg2_beaa", 64'(rq_reg(2)), 64'(32'hDEAD_BEAA));
        check("wready_back", 64'(bus.WREADY), 64'(1));

        // R back-pressure: data held, ARREADY low until R handshake
        bus.ARADDR = 32'h08; bus.ARPROT = 3'b001; bus.ARVALID = 1'b1;
        @(negedge aclk);
        cyc();
        bus.ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("r_hold", 64'({bus.RVALID, bus.ARREADY, bus.RDATA}), 64'({1'b1, 1'b0, 32'hDEAD_BEAA}));
            cyc();
        end
        bus.RREADY = 1'b1;
        @(negedge aclk);
        cyc();
        bus.RREADY = 1'b0;
        @(negedge aclk);
        check("r_released", 64'({bus.RVALID, bus.ARREADY}), 64'(2'b01));
        cyc();

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) begin
                axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].prot, tbl[i].resp);
                if (tbl[i].resp == OKAY) mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            end else begin
                axi_read(tbl[i].addr, tbl[i].prot, tbl[i].resp, tbl[i].data);
            end
        end

        // Same-edge read and commit to idx 3: read sees the old value
        bus.AWADDR = 32'h0C; bus.AWPROT = 3'b001; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h0000_0002; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge aclk);
        cyc();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        bus.ARADDR = 32'h0C; bus.ARPROT = 3'b001; bus.ARVALID = 1'b1;
        @(negedge aclk);
        cyc();
        bus.ARVALID = 1'b0;
        @(negedge aclk);
        check("collision_old", 64'({bus.RVALID, bus.RDATA}), 64'({1'b1, 32'h0000_0001}));
        check("collision_reg3", 64'(rq_reg(3)), 64'(32'h0000_0002));
        bus.RREADY = 1'b1; bus.BREADY = 1'b1;
        cyc();
        bus.RREADY = 1'b0; bus.BREADY = 1'b0;
        mdl[3] = 32'h0000_0002;
        axi_read(32'h0C, 3'b001, OKAY, 32'h0000_0002);

        // Whole bank against the bench model
        for (int i = 0; i < int'(NREGS); i++) begin
            check($sformatf("reg_q[%0d]", i), 64'(rq_reg(i)), 64'(mdl[i]));
        end

        // Reset mid-transaction: held AW and pending R are dropped
        bus.AWADDR = 32'h1C; bus.AWVALID = 1'b1;
        bus.ARADDR = 32'h08; bus.ARVALID = 1'b1;
        @(negedge aclk);
        cyc();
        bus.AWVALID = 1'b0; bus.ARVALID = 1'b0;
        areset = 1'b1;
        cyc();
        areset = 1'b0;
        @(negedge aclk);
        check("rst_mid_drop", 64'({bus.RVALID, bus.AWREADY, bus.BVALID}), 64'(3'b010));
        cyc();
        bus.WDATA = 32'h0000_0055; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        @(negedge aclk);
        cyc();
        bus.WVALID = 1'b0;
        repeat (4) cyc();
        @(negedge aclk);
        check("no_commit_after_rst", 64'(bus.BVALID), 64'(0));
        cyc();
        bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
        bq.push_back(OKAY);
        @(negedge aclk);
        cyc();
        bus.AWVALID = 1'b0;
        wait_b();
        check("rst_reg2", 64'(rq_reg(2)), 64'(0));
        check("rst_reg7", 64'(rq_reg(7)), 64'(0));
        check("reg8_after_rst", 64'(rq_reg(8)), 64'(32'h0000_0055));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
